rcpu_io_uart: RTL and testbench
===============================

Name: rcpu_io_uart

Overview:
- Memory-mapped UART peripheral on the CPU's IO bus (io_read_enable/io_write_enable/io_addr/io_write_data/io_read_data).
- Consumes the CPU's IO writes into a TX FIFO and serialises them onto uart_tx.
- Deserialises uart_rx into a one-byte receive holding register.
- Returns registered status and data on IO reads with the same one-cycle read latency as the RAM.

Parameters:
- CLK_DIV, 104, clk cycles per UART bit (>=4, even).
- TX_DEPTH, 8, TX FIFO entries (power of 2, >=2).
- BASE_ADDR, 16'hFF00, IO address of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- io_read_enable  in  1  IO read strobe, one cycle per access.
- io_write_enable  in  1  IO write strobe, one cycle per access.
- io_addr  in  [0:15]  IO address.
- io_write_data  in  [0:15]  write data; bit 15 is the LSB.
- io_read_data  out  [0:15]  registered read data.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Bit numbering is [0:15]: "bit 15" means the LSB. Bytes use io_data[8:15].
- Register map:
  - +0 TXDATA, write-only: push io_write_data[8:15]. Reads return 0.
  - +1 RXDATA, read: {8'h00, rx_byte}, and clears rx_valid (pop). Writes are ignored.
  - +2 STATUS, read: bit15 tx_full, bit14 tx_empty, bit13 rx_valid, bit12 rx_overrun, bit11 tx_busy, bit10 frame_err, all other bits 0. Write with bit12=1 clears rx_overrun and frame_err; other bits are ignored.
- Reset values:
  - io_read_data=0, uart_tx=1.
  - FIFO empty, rx_valid=0, rx_overrun=0, frame_err=0, rx_byte=0.
  - Both FSMs in IDLE.
  - Reset mid-frame aborts immediately: uart_tx=1 on the next edge, and the FIFO contents are lost.
- Read latency:
  - io_read_enable at edge N gives io_read_data valid after edge N, reflecting state before edge N.
  - Addresses outside the map load 0.
  - With io_read_enable low, io_read_data holds its value.
- Write/read collision: io_read_enable and io_write_enable high together are both honoured.
- TX FIFO:
  - A push is accepted only if tx_full=0 at the start of the cycle. A push while full is dropped silently, even if TX pops in the same cycle.
  - Pointer wrap is modulo TX_DEPTH. Occupancy counter width is clog2(TX_DEPTH)+1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop and go to START.
  - START: drive 0 for CLK_DIV cycles.
  - DATA: drive 8 bits LSB first, CLK_DIV cycles each, counted by a bit counter 0..7.
  - STOP: drive 1 for CLK_DIV cycles, then IDLE.
  - Back-to-back bytes have no extra idle cycles beyond one IDLE cycle.
  - tx_busy=1 in any state other than IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchroniser, reset value 1.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronised falling edge goes to START.
  - START: at CLK_DIV/2, if the line is still 0 go to DATA; else glitch, back to IDLE.
  - DATA: sample every CLK_DIV cycles at mid-bit, LSB first, 8 bits.
  - STOP: sample at mid-bit.
    - If 1 and rx_valid=0: rx_byte=data, rx_valid=1.
    - If 1 and rx_valid=1: set rx_overrun, discard the new byte, keep the old byte.
    - If 0: set frame_err, discard the byte.
  - After STOP, return to IDLE and wait for the next falling edge.
- Simultaneous pop and receive completion in the same cycle: the new byte is stored, rx_valid stays 1, and rx_overrun is not set.
- Sticky clear and new error event in the same cycle: the set wins.

Test Plan (CLK_DIV=4, TX_DEPTH=4, BASE_ADDR=16'hFF00):
- Reset then read STATUS.
  - Required: io_read_data=16'h0002 one cycle after the strobe, uart_tx=1.
- Write 16'h1255 to FF00.
  - Required: start bit begins within 2 cycles; uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; 0x55 is sent LSB first.
  - Required: STATUS bit11 is 1 during the frame and 0 after it.
- Write 5 bytes A1..A5 back-to-back.
  - Required: tx_full=1 after the 4th write if TX has not popped yet; the 5th byte is dropped or accepted strictly per the start-of-cycle full rule.
  - Required: the serial output matches the accepted bytes in order.
- Drive uart_rx with frame 0x3C.
  - Required: STATUS=16'h0006 (tx_empty|rx_valid); RXDATA read returns 16'h003C; the next STATUS read is 16'h0002.
- Two frames 0x11, 0x22 without popping.
  - Required: RXDATA=16'h0011 and rx_overrun=1; a STATUS write of 16'h0008 clears it.
- Frame with stop bit 0.
  - Required: frame_err (16'h0020 set in STATUS), rx_valid unchanged.
- 1-cycle low glitch on uart_rx.
  - Required: no byte received.
- Reset asserted mid-TX frame.
  - Required: uart_tx=1 on the next edge, tx_empty=1.

Source files
------------

// File: rtl/rcpu_io_uart.sv
// rcpu_io_uart: memory-mapped UART on the CPU IO bus.
// Register map at BASE_ADDR: +0 TXDATA (push), +1 RXDATA (pop), +2 STATUS.
// Bus vectors are numbered [0:15], so bit 15 is the LSB and bytes live in [8:15].
module rcpu_io_uart #(
    parameter int          CLK_DIV   = 104,
    parameter int          TX_DEPTH  = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [0:15] io_addr,
    input  logic [0:15] io_write_data,
    output logic [0:15] io_read_data,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int AW   = $clog2(TX_DEPTH);
    localparam int CW   = AW + 1;
    localparam int DIVW = $clog2(CLK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
    // START is entered one cycle after the line is seen low, so load two short of half a bit
    localparam logic [DIVW-1:0] HALF_LOAD = DIVW'(CLK_DIV / 2 - 2);
    localparam logic [15:0] ADDR_TX = BASE_ADDR;
    localparam logic [15:0] ADDR_RX = BASE_ADDR + 16'd1;
    localparam logic [15:0] ADDR_ST = BASE_ADDR + 16'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [7:0]      r_fifo [TX_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_count;
    logic            w_tx_full, w_tx_empty, w_push, w_pop;

    tx_state_t       r_tx_state, w_tx_next;
    logic [DIVW-1:0] r_tx_cnt, w_tx_cnt_next;
    logic [2:0]      r_tx_bit, w_tx_bit_next;
    logic [7:0]      r_tx_shift, w_tx_shift_next;
    logic            r_tx_line, w_tx_line_next;

    logic [1:0]      r_rx_sync;
    logic            r_rx_prev, w_rx;
    rx_state_t       r_rx_state, w_rx_next;
    logic [DIVW-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]      r_rx_bit, w_rx_bit_next;
    logic [7:0]      r_rx_shift, w_rx_shift_next;
    logic            w_rx_done;

    logic [7:0]      r_rx_byte;
    logic            r_rx_valid, r_overrun, r_frame_err;
    logic            w_rd_rx, w_clr;
    logic [0:15]     w_status, r_rd;
    logic            w_unused;

    assign w_tx_full  = (r_count == CW'(TX_DEPTH));
    assign w_tx_empty = (r_count == '0);
    assign w_push     = io_write_enable && (io_addr == ADDR_TX) && !w_tx_full;
    assign w_pop      = (r_tx_state == TX_IDLE) && !w_tx_empty;
    assign w_rx       = r_rx_sync[1];
    assign w_rd_rx    = io_read_enable && (io_addr == ADDR_RX);
    assign w_clr      = io_write_enable && (io_addr == ADDR_ST) && io_write_data[12];
    assign uart_tx      = r_tx_line;
    assign io_read_data = r_rd;
    assign w_unused   = ^io_write_data[0:7];

    // TX FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= io_write_data[8:15];
    end

    // TX FIFO pointers and occupancy; full is judged at start of cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // TX state register and serialiser datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_line  <= w_tx_line_next;
        end
    end

    // TX next state: line level is registered so it changes with the state
    always_comb begin
        w_tx_next       = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_line_next  = r_tx_line;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_line_next = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_next       = TX_START;
                    w_tx_cnt_next   = DIV_LAST;
                    w_tx_shift_next = r_fifo[r_rp];
                    w_tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == '0) begin
                    w_tx_next      = TX_DATA;
                    w_tx_cnt_next  = DIV_LAST;
                    w_tx_bit_next  = 3'd0;
                    w_tx_line_next = r_tx_shift[0];
                end else w_tx_cnt_next = r_tx_cnt - 1'b1;
            end
            TX_DATA: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_next = DIV_LAST;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_next      = TX_STOP;
                        w_tx_line_next = 1'b1;
                    end else begin
                        w_tx_bit_next   = r_tx_bit + 3'd1;
                        w_tx_shift_next = r_tx_shift >> 1;
                        w_tx_line_next  = r_tx_shift[1];
                    end
                end else w_tx_cnt_next = r_tx_cnt - 1'b1;
            end
            TX_STOP: begin
                if (r_tx_cnt == '0) w_tx_next = TX_IDLE;
                else                w_tx_cnt_next = r_tx_cnt - 1'b1;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // RX synchroniser, previous-sample flop for edge detect, and RX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], uart_rx};
            r_rx_prev  <= w_rx;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    // RX next state: mid-bit sampling driven by the down-counter reaching zero
    always_comb begin
        w_rx_next       = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_done       = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !w_rx) begin
                    w_rx_next     = RX_START;
                    w_rx_cnt_next = HALF_LOAD;
                end
            end
            RX_START: begin
                if (r_rx_cnt == '0) begin
                    if (!w_rx) begin
                        w_rx_next     = RX_DATA;
                        w_rx_cnt_next = DIV_LAST;
                        w_rx_bit_next = 3'd0;
                    end else w_rx_next = RX_IDLE;
                end else w_rx_cnt_next = r_rx_cnt - 1'b1;
            end
            RX_DATA: begin
                if (r_rx_cnt == '0) begin
                    w_rx_shift_next = {w_rx, r_rx_shift[7:1]};
                    w_rx_cnt_next   = DIV_LAST;
                    if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
                    else                  w_rx_bit_next = r_rx_bit + 3'd1;
                end else w_rx_cnt_next = r_rx_cnt - 1'b1;
            end
            RX_STOP: begin
                if (r_rx_cnt == '0) begin
                    w_rx_done = 1'b1;
                    w_rx_next = RX_IDLE;
                end else w_rx_cnt_next = r_rx_cnt - 1'b1;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Receive holding register and sticky errors; a new error beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_clr) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_rx_done && w_rx) begin
                if (r_rx_valid && !w_rd_rx) r_overrun <= 1'b1;
                else begin
                    r_rx_byte  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (w_rd_rx) r_rx_valid <= 1'b0;
            if (w_rx_done && !w_rx) r_frame_err <= 1'b1;
        end
    end

    // STATUS word assembly
    always_comb begin
        w_status     = '0;
        w_status[15] = w_tx_full;
        w_status[14] = w_tx_empty;
        w_status[13] = r_rx_valid;
        w_status[12] = r_overrun;
        w_status[11] = (r_tx_state != TX_IDLE);
        w_status[10] = r_frame_err;
    end

    // Registered read data, held while no read is strobed
    always_ff @(posedge clk) begin
        if (reset) r_rd <= '0;
        else if (io_read_enable) begin
            case (io_addr)
                ADDR_RX: r_rd <= {8'h00, r_rx_byte};
                ADDR_ST: r_rd <= w_status;
                default: r_rd <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_rcpu_io_uart.sv
// Bench for rcpu_io_uart: TX bytes scoreboarded through a queue, RX and
// status checked through directed bus reads.
module tb_rcpu_io_uart;
    localparam int          D    = 4;
    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_read_enable = 1'b0;
    logic        io_write_enable = 1'b0;
    logic [0:15] io_addr = '0;
    logic [0:15] io_write_data = '0;
    logic [0:15] io_read_data;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] tx_q[$];
    logic [15:0] rd;

    rcpu_io_uart #(.CLK_DIV(D), .TX_DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
        .io_addr(io_addr), .io_write_data(io_write_data), .io_read_data(io_read_data),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // bus tasks start and end on a negedge so calls can run back-to-back
    task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
        io_write_enable = 1'b1; io_addr = a; io_write_data = d;
        @(posedge clk); @(negedge clk);
        io_write_enable = 1'b0;
    endtask

    task automatic io_rd(input logic [15:0] a, output logic [15:0] d);
        io_read_enable = 1'b1; io_addr = a;
        @(posedge clk); @(negedge clk);
        io_read_enable = 1'b0;
        d = io_read_data;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0; repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i]; repeat (D) @(negedge clk);
        end
        uart_rx = stop; repeat (D) @(negedge clk);
        uart_rx = 1'b1; repeat (2 * D) @(negedge clk);
    endtask

    task automatic wait_tx_done(input int budget);
        int n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            @(negedge clk); n++;
        end
        check("tx_drain", 16'(tx_q.size()), 16'h0000);
        repeat (2 * D) @(negedge clk);
    endtask

    // TX monitor: finds a start bit, samples every bit mid-period, pops the scoreboard
    initial begin
        logic [7:0]  b;
        logic        st, sp, ab;
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                ab = 1'b0; st = 1'b1; sp = 1'b0; b = '0;
                for (int k = 1; k <= 9 * D + D / 2; k++) begin
                    @(negedge clk);
                    if (reset) ab = 1'b1;
                    if (k == D / 2) st = uart_tx;
                    if (k >= D + D / 2 && k <= 8 * D + D / 2 && (k - D / 2) % D == 0)
                        b[(k - D / 2) / D - 1] = uart_tx;
                    if (k == 9 * D + D / 2) sp = uart_tx;
                end
                if (!ab) begin
                    exp = (tx_q.size() != 0) ? {8'h00, tx_q.pop_front()} : 16'h0100;
                    check("tx_byte", {8'h00, b}, exp);
                    check("tx_start_bit", {15'h0, st}, 16'h0000);
                    check("tx_stop_bit", {15'h0, sp}, 16'h0001);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        io_rd(BASE + 16'd2, rd);
        check("reset_status", rd, 16'h0002);
        check("reset_tx_idle", {15'h0, uart_tx}, 16'h0001);

        // single byte 0x55
        tx_q.push_back(8'h55);
        io_wr(BASE, 16'h1255);
        @(negedge clk);
        check("tx_start_latency", {15'h0, uart_tx}, 16'h0000);
        io_rd(BASE + 16'd2, rd);
        check("status_busy", rd, 16'h0012);
        wait_tx_done(100);
        io_rd(BASE + 16'd2, rd);
        check("status_after_frame", rd, 16'h0002);

        // fill the FIFO while a frame is in flight; fifth push must be dropped
        tx_q.push_back(8'h77);
        io_wr(BASE, 16'h0077);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            tx_q.push_back(8'hA0 + 8'(i));
            io_wr(BASE, 16'h00A0 + 16'(i));
        end
        io_rd(BASE + 16'd2, rd);
        check("status_full", rd, 16'h0011);
        io_wr(BASE, 16'h00A5);
        io_rd(BASE, rd);
        check("txdata_reads_zero", rd, 16'h0000);
        wait_tx_done(400);

        // clean receive
        send_rx(8'h3C, 1'b1);
        io_rd(BASE + 16'd2, rd);
        check("rx_status_valid", rd, 16'h0006);
        io_rd(BASE + 16'd1, rd);
        check("rx_data", rd, 16'h003C);
        io_rd(BASE + 16'd2, rd);
        check("rx_status_popped", rd, 16'h0002);

        // overrun keeps the first byte
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        io_rd(BASE + 16'd2, rd);
        check("overrun_status", rd, 16'h000E);
        io_rd(BASE + 16'd1, rd);
        check("overrun_data", rd, 16'h0011);
        io_wr(BASE + 16'd2, 16'h0008);
        io_rd(BASE + 16'd2, rd);
        check("overrun_cleared", rd, 16'h0002);

        // framing error leaves the held byte alone
        send_rx(8'h33, 1'b1);
        send_rx(8'h5A, 1'b0);
        io_rd(BASE + 16'd2, rd);
        check("frame_err_status", rd, 16'h0026);
        io_rd(BASE + 16'd1, rd);
        check("frame_err_data", rd, 16'h0033);
        io_wr(BASE + 16'd2, 16'h0008);
        io_rd(BASE + 16'd2, rd);
        check("frame_err_cleared", rd, 16'h0002);

        // one-cycle glitch must not start a reception
        uart_rx = 1'b0; @(negedge clk);
        uart_rx = 1'b1; repeat (12 * D) @(negedge clk);
        io_rd(BASE + 16'd2, rd);
        check("glitch_ignored", rd, 16'h0002);

        io_rd(BASE + 16'h0010, rd);
        check("unmapped_read", rd, 16'h0000);

        // reset mid-frame with bytes still queued
        io_wr(BASE, 16'h0099);
        io_wr(BASE, 16'h0098);
        io_wr(BASE, 16'h0097);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        tx_q.delete();
        @(posedge clk); @(negedge clk);
        check("reset_tx_high", {15'h0, uart_tx}, 16'h0001);
        check("reset_rdata", io_read_data, 16'h0000);
        reset = 1'b0;
        io_rd(BASE + 16'd2, rd);
        check("reset_fifo_empty", rd, 16'h0002);
        repeat (12 * D) @(negedge clk);
        check("no_tx_after_reset", {15'h0, uart_tx}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
